// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive controller.
// Holds the lock FSM states, channel/justify codes and counter sizing.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    CHECK,
    LOCKED
  } i2s_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam logic JUST_I2S  = 1'b0;
  localparam logic JUST_LEFT = 1'b1;

  // Bit counter holds 0..64; 64 with no ws edge is a forced restart.
  localparam int              CNT_W   = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = 7'd64;

  localparam int GCNT_W = 5;

endpackage

// File: rtl/i2s_slot_timer.sv
// Slot timing for the I2S receiver: ws edge detect, bit counter,
// capture-window strobe and registered slot-good/slot-bad pulses.
// Ports: i_clk/i_rst clock and sync reset; i_ws word select;
//   i_just effective justify mode; o_start slot starts this edge;
//   o_cap sd bit belongs to the slot being captured; o_edge_q,
//   o_good_q, o_bad_q, o_ch_q registered edge/slot-end results.
module i2s_slot_timer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ws,
  input  logic i_just,
  output logic o_start,
  output logic o_cap,
  output logic o_edge_q,
  output logic o_good_q,
  output logic o_bad_q,
  output logic o_ch_q
);

  localparam logic [CNT_W-1:0] SAMP = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] SLOT = CNT_W'(SLOT_W);

  logic             r_ws_q;
  logic             r_ws_vld;
  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic             r_edge;
  logic             r_good;
  logic             r_bad;
  logic             r_ch;

  logic w_edge;
  logic w_ovf;
  logic w_start;
  logic w_good;
  logic w_bad;
  logic w_win;

  always_comb begin
    w_edge  = r_ws_vld && (i_ws != r_ws_q);
    w_ovf   = r_active && !w_edge &&
              (r_cnt == CNT_MAX);
    w_start = w_edge || w_ovf;
    w_good  = w_edge && r_active &&
              (r_cnt == SLOT);
    w_bad   = r_active && w_start && !w_good;
    // r_cnt still describes the slot in progress, so an I2S LSB
    // landing on the closing edge is kept with its own slot.
    if (i_just == JUST_LEFT) begin
      w_win = (r_cnt != '0) && (r_cnt < SAMP);
    end else begin
      w_win = (r_cnt != '0) && (r_cnt <= SAMP);
    end
  end

  assign o_start  = w_start;
  assign o_cap    = r_active && w_win;
  assign o_edge_q = r_edge;
  assign o_good_q = r_good;
  assign o_bad_q  = r_bad;
  assign o_ch_q   = r_ch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ws_q   <= 1'b0;
      r_ws_vld <= 1'b0;
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_edge   <= 1'b0;
      r_good   <= 1'b0;
      r_bad    <= 1'b0;
      r_ch     <= 1'b0;
    end else begin
      r_ws_q   <= i_ws;
      r_ws_vld <= 1'b1;
      if (w_start) begin
        r_active <= 1'b1;
        r_cnt    <= CNT_W'(1);
      end else if (r_active) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_edge <= w_edge;
      r_good <= w_good;
      r_bad  <= w_bad;
      r_ch   <= r_ws_q;
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S receive controller: lock FSM, sample shift register and a
// valid/ready holding register for completed left/right pairs.
// Ports: sck/rst clock and sync reset; ws, sd I2S pins; enable,
//   justify mode controls; out_left/out_right/out_valid/out_ready
//   pair handshake; locked, frame_err, overflow status.
module i2s_rx_ctrl
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = 24,
  parameter int SLOT_W      = 32,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                sck,
  input  logic                rst,
  input  logic                ws,
  input  logic                sd,
  input  logic                enable,
  input  logic                justify,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                locked,
  output logic                frame_err,
  output logic                overflow
);

  localparam logic [GCNT_W-1:0] GOOD_N =
    GCNT_W'(2 * LOCK_FRAMES);

  i2s_state_t r_state;
  i2s_state_t w_state_nxt;

  logic [GCNT_W-1:0]  r_good_cnt;
  logic               r_just;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_slot_data;
  logic [SAMPLE_W-1:0] r_left_hold;
  logic               r_have_left;
  logic [SAMPLE_W-1:0] r_out_l;
  logic [SAMPLE_W-1:0] r_out_r;
  logic               r_valid;
  logic               r_ferr;
  logic               r_ovf;

  logic w_start;
  logic w_cap;
  logic w_edge_q;
  logic w_good_q;
  logic w_bad_q;
  logic w_ch_q;

  logic w_just;
  logic w_locked;
  logic w_in_lock;
  logic w_ferr_d;
  logic w_cnt_inc;
  logic w_cnt_hold;
  logic w_pair;

  logic [SAMPLE_W:0]   w_shift_ext;
  logic [SAMPLE_W-1:0] w_shift_nxt;
  logic [SAMPLE_W-1:0] w_first;

  i2s_slot_timer #(
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W)
  ) u_timer (
    .i_clk    (sck),
    .i_rst    (rst),
    .i_ws     (ws),
    .i_just   (w_just),
    .o_start  (w_start),
    .o_cap    (w_cap),
    .o_edge_q (w_edge_q),
    .o_good_q (w_good_q),
    .o_bad_q  (w_bad_q),
    .o_ch_q   (w_ch_q)
  );

  always_ff @(posedge sck) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: w_state_nxt = HUNT;
        HUNT: begin
          if (w_edge_q) w_state_nxt = CHECK;
        end
        CHECK: begin
          if (w_good_q &&
              (r_good_cnt + GCNT_W'(1) == GOOD_N))
            w_state_nxt = LOCKED;
        end
        LOCKED: begin
          if (w_bad_q) w_state_nxt = CHECK;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_just     = r_just;
    w_locked   = 1'b0;
    w_in_lock  = 1'b0;
    w_ferr_d   = 1'b0;
    w_cnt_inc  = 1'b0;
    w_cnt_hold = 1'b0;
    unique case (r_state)
      IDLE, HUNT: w_just = justify;
      CHECK: begin
        w_cnt_inc  = enable && w_good_q;
        w_cnt_hold = enable && !w_bad_q;
        w_ferr_d   = enable && w_bad_q;
      end
      LOCKED: begin
        w_locked  = 1'b1;
        w_in_lock = enable;
        w_ferr_d  = enable && w_bad_q;
      end
      default: w_just = r_just;
    endcase
  end

  always_comb begin
    w_shift_ext = {r_shift, sd};
    w_shift_nxt = w_cap ? w_shift_ext[SAMPLE_W-1:0]
                        : r_shift;
    // Left-justified data carries its MSB on the ws edge itself.
    w_first     = '0;
    w_first[0]  = (w_just == JUST_LEFT) ? sd : 1'b0;
    w_pair      = w_in_lock && w_good_q &&
                  (w_ch_q == CH_RIGHT) && r_have_left;
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      r_good_cnt  <= '0;
      r_just      <= JUST_I2S;
      r_shift     <= '0;
      r_slot_data <= '0;
      r_left_hold <= '0;
      r_have_left <= 1'b0;
      r_out_l     <= '0;
      r_out_r     <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (r_state == IDLE || r_state == HUNT)
        r_just <= justify;

      if (w_cnt_inc) begin
        r_good_cnt <= r_good_cnt + GCNT_W'(1);
      end else if (!w_cnt_hold) begin
        r_good_cnt <= '0;
      end

      if (w_start) begin
        r_slot_data <= w_shift_nxt;
        r_shift     <= w_first;
      end else begin
        r_shift <= w_shift_nxt;
      end

      // A left sample is only usable if the very next slot is a
      // good right; anything else drops it.
      if (w_in_lock && w_good_q && (w_ch_q == CH_LEFT)) begin
        r_left_hold <= r_slot_data;
        r_have_left <= 1'b1;
      end else if (!w_in_lock || w_good_q || w_bad_q) begin
        r_have_left <= 1'b0;
      end

      r_ovf  <= w_pair && r_valid && !out_ready;
      r_ferr <= w_ferr_d;

      if (w_pair && (!r_valid || out_ready)) begin
        r_out_l <= r_left_hold;
        r_out_r <= r_slot_data;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_left  = r_out_l;
  assign out_right = r_out_r;
  assign out_valid = r_valid;
  assign locked    = w_locked;
  assign frame_err = r_ferr;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Self-checking bench for i2s_rx_ctrl: lock-up, justify modes,
// bad slots, backpressure, reset and enable drop.
module tb_i2s_rx_ctrl;

  localparam int SW = 24;

  logic          sck = 1'b0;
  logic          rst;
  logic          ws;
  logic          sd;
  logic          enable;
  logic          justify;
  logic [SW-1:0] out_left;
  logic [SW-1:0] out_right;
  logic          out_valid;
  logic          out_ready;
  logic          locked;
  logic          frame_err;
  logic          overflow;

  always #5 sck = ~sck;

  i2s_rx_ctrl #(
    .SAMPLE_W    (24),
    .SLOT_W      (32),
    .LOCK_FRAMES (2)
  ) dut (
    .sck       (sck),
    .rst       (rst),
    .ws        (ws),
    .sd        (sd),
    .enable    (enable),
    .justify   (justify),
    .out_left  (out_left),
    .out_right (out_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } pair_t;

  typedef struct {
    logic          just;
    logic          lj;
    logic [SW-1:0] el;
    logic [SW-1:0] er;
  } vec_t;

  localparam logic [31:0] WA = 32'hA5A5A5A5;
  localparam logic [31:0] WB = 32'h3C3C3C3C;

  pair_t exp_q[$];
  vec_t  vt[3];
  int    checks   = 0;
  int    failures = 0;
  int    n_hs     = 0;
  int    n_ferr   = 0;
  int    n_ovf    = 0;
  logic  prev_lsb = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               name, act, req);
    end
  endtask

  always @(negedge sck) begin : mon
    pair_t e;
    if (frame_err === 1'b1) n_ferr++;
    if (overflow === 1'b1) n_ovf++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pair: got %h/%h want none",
                 out_left, out_right);
      end else begin
        e = exp_q.pop_front();
        check("pair_left", 64'(out_left), 64'(e.l));
        check("pair_right", 64'(out_right), 64'(e.r));
      end
    end
  end

  task automatic tick();
    @(posedge sck);
    #2;
  endtask

  task automatic push(input logic [SW-1:0] l,
                      input logic [SW-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
  endtask

  // Drives positions k0..k1-1 of a slot. I2S streams lag the word
  // by one bit, with the previous word's LSB on the ws edge.
  task automatic slot(input logic ch, input logic [31:0] w,
                      input int k0, input int k1,
                      input logic lj);
    for (int k = k0; k < k1; k++) begin
      ws = ch;
      if (lj)
        sd = (k < 32) ? w[31-k] : 1'b0;
      else if (k == 0)
        sd = prev_lsb;
      else
        sd = (k <= 32) ? w[32-k] : 1'b0;
      tick();
    end
    prev_lsb = w[0];
  endtask

  task automatic frame(input logic [31:0] l,
                       input logic [31:0] r,
                       input logic lj);
    slot(1'b0, l, 0, 32, lj);
    slot(1'b1, r, 0, 32, lj);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    justify   = 1'b0;
    ws        = 1'b0;
    sd        = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    exp_q.delete();
    n_hs     = 0;
    n_ferr   = 0;
    n_ovf    = 0;
    prev_lsb = 1'b0;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
  endtask

  // L1 is never judged; R1,L2,R2,L3 are the four good slots.
  task automatic lock_up();
    frame(WA, WB, 1'b0);
    frame(WA, WB, 1'b0);
    slot(1'b0, WA, 0, 32, 1'b0);
    slot(1'b1, WB, 0, 32, 1'b0);
  endtask

  initial begin
    vt[0] = '{just: 1'b0, lj: 1'b0,
              el: 24'hA5A5A5, er: 24'h3C3C3C};
    vt[1] = '{just: 1'b1, lj: 1'b1,
              el: 24'hA5A5A5, er: 24'h3C3C3C};
    vt[2] = '{just: 1'b0, lj: 1'b1,
              el: 24'h4B4B4B, er: 24'h787878};

    do_reset();
    check("rst_left", 64'(out_left), 64'h0);
    check("rst_right", 64'(out_right), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);
    check("rst_ferr", 64'(frame_err), 64'h0);
    check("rst_ovf", 64'(overflow), 64'h0);

    for (int i = 0; i < 3; i++) begin
      do_reset();
      justify = vt[i].just;
      start();
      frame(WA, WB, vt[i].lj);
      frame(WA, WB, vt[i].lj);
      slot(1'b0, WA, 0, 32, vt[i].lj);
      slot(1'b1, WB, 0, 1, vt[i].lj);
      check("lock_early", 64'(locked), 64'h0);
      slot(1'b1, WB, 1, 2, vt[i].lj);
      check("lock_rise", 64'(locked), 64'h1);
      slot(1'b1, WB, 2, 32, vt[i].lj);
      push(vt[i].el, vt[i].er);
      push(vt[i].el, vt[i].er);
      repeat (3) frame(WA, WB, vt[i].lj);
      sd = 1'b0;
      repeat (4) tick();
      check("pair_count", 64'(n_hs), 64'd2);
      check("lock_hold", 64'(locked), 64'h1);
      check("q_empty", 64'(exp_q.size()), 64'd0);
    end

    // Short right slot while locked.
    do_reset();
    start();
    lock_up();
    push(24'hA5A5A5, 24'h3C3C3C);
    frame(WA, WB, 1'b0);
    slot(1'b0, 32'h11223344, 0, 32, 1'b0);
    slot(1'b1, 32'h55667788, 0, 31, 1'b0);
    slot(1'b0, WA, 0, 3, 1'b0);
    check("bad_ferr", 64'(n_ferr), 64'd1);
    check("bad_unlock", 64'(locked), 64'h0);
    slot(1'b0, WA, 3, 32, 1'b0);
    slot(1'b1, WB, 0, 32, 1'b0);
    frame(WA, WB, 1'b0);
    push(24'hDEADBE, 24'h0BADF0);
    frame(32'hDEADBEEF, 32'h0BADF00D, 1'b0);
    slot(1'b0, WA, 0, 4, 1'b0);
    check("relock", 64'(locked), 64'h1);
    check("bad_ferr_once", 64'(n_ferr), 64'd1);
    check("bad_pairs", 64'(n_hs), 64'd2);
    check("bad_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: hold the first pair, drop two.
    do_reset();
    out_ready = 1'b0;
    start();
    lock_up();
    push(24'h123456, 24'h9ABCDE);
    frame(32'h12345678, 32'h9ABCDEF0, 1'b0);
    frame(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
    frame(32'h00FF00FF, 32'hFF00FF00, 1'b0);
    frame(32'hCAFEBABE, 32'h87654321, 1'b0);
    check("bp_valid", 64'(out_valid), 64'h1);
    check("bp_left", 64'(out_left), 64'h123456);
    check("bp_ovf", 64'(n_ovf), 64'd2);
    slot(1'b0, WA, 0, 1, 1'b0);
    out_ready = 1'b1;
    push(24'hCAFEBA, 24'h876543);
    slot(1'b0, WA, 1, 2, 1'b0);
    check("bp_valid_stays", 64'(out_valid), 64'h1);
    check("bp_new_left", 64'(out_left), 64'hCAFEBA);
    slot(1'b0, WA, 2, 6, 1'b0);
    check("bp_drained", 64'(out_valid), 64'h0);
    check("bp_pairs", 64'(n_hs), 64'd2);
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid right slot with a pending pair.
    do_reset();
    out_ready = 1'b0;
    start();
    lock_up();
    frame(32'h12345678, 32'h9ABCDEF0, 1'b0);
    slot(1'b0, WA, 0, 32, 1'b0);
    slot(1'b1, WB, 0, 10, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_left", 64'(out_left), 64'h0);
    check("mid_rst_right", 64'(out_right), 64'h0);
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_locked", 64'(locked), 64'h0);
    check("mid_rst_ferr", 64'(frame_err), 64'h0);
    check("mid_rst_ovf", 64'(overflow), 64'h0);
    rst = 1'b0;
    slot(1'b1, WB, 11, 32, 1'b0);
    frame(WA, WB, 1'b0);
    frame(WA, WB, 1'b0);
    slot(1'b0, WA, 0, 3, 1'b0);
    check("rst_relock", 64'(locked), 64'h1);
    check("rst_no_ferr", 64'(n_ferr), 64'd0);

    // Enable drop while locked with a pending pair.
    do_reset();
    out_ready = 1'b0;
    start();
    lock_up();
    push(24'h123456, 24'h9ABCDE);
    frame(32'h12345678, 32'h9ABCDEF0, 1'b0);
    slot(1'b0, WA, 0, 5, 1'b0);
    check("en_pre_valid", 64'(out_valid), 64'h1);
    enable = 1'b0;
    slot(1'b0, WA, 5, 6, 1'b0);
    check("en_unlock", 64'(locked), 64'h0);
    check("en_keep_valid", 64'(out_valid), 64'h1);
    check("en_keep_left", 64'(out_left), 64'h123456);
    slot(1'b0, WA, 6, 10, 1'b0);
    out_ready = 1'b1;
    slot(1'b0, WA, 10, 13, 1'b0);
    check("en_drained", 64'(out_valid), 64'h0);
    check("en_pairs", 64'(n_hs), 64'd1);
    check("en_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
